// File: rtl/r2b_pkg.sv
// Shared constants, types and address helpers for the raster_to_block reorder buffer.
package r2b_pkg;

  localparam int W_IO   = 16;
  localparam int MAX_BW = 80;
  localparam int BW_W   = $clog2(MAX_BW + 1);
  localparam int COL_W  = (MAX_BW > 1) ? $clog2(MAX_BW) : 1;
  localparam int DEPTH  = 2 * 8 * MAX_BW;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [7:0][W_IO-1:0] row_t;

  typedef enum logic {IDLE, RUN} r2b_state_t;

  // Width 0 means one block; anything wider than the RAM is clamped.
  function automatic logic [BW_W-1:0] sat_bw(input logic [BW_W-1:0] cfg);
    if (cfg == '0)
      return BW_W'(1);
    else if (cfg > BW_W'(MAX_BW))
      return BW_W'(MAX_BW);
    else
      return cfg;
  endfunction

  function automatic logic [ADDR_W-1:0] strip_addr(input logic sel, input logic [2:0] line,
                                                   input logic [COL_W-1:0] col);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(line) * ADDR_W'(MAX_BW) + ADDR_W'(col);
    if (sel)
      a = a + ADDR_W'(8 * MAX_BW);
    return a;
  endfunction

endpackage

// File: rtl/r2b_strip_ram.sv
// Two-strip row store: one write port, one registered read port, both held when en is low.
module r2b_strip_ram
  import r2b_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [2:0]       wr_line,
  input  logic [COL_W-1:0] wr_col,
  input  row_t             wr_data,
  input  logic             rd_en,
  input  logic             rd_sel,
  input  logic [2:0]       rd_line,
  input  logic [COL_W-1:0] rd_col,
  output row_t             rd_data
);

  row_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && wr_en)
      mem[strip_addr(wr_sel, wr_line, wr_col)] <= wr_data;
  end

  // Read register doubles as the block's output data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else if (en && rd_en)
      rd_data <= mem[strip_addr(rd_sel, rd_line, rd_col)];
  end

endmodule

// File: rtl/raster_to_block.sv
// Raster-line to 8x8 block reorder buffer with double-buffered strips.
// Optional JPEG level shift on the output lanes when R2B_LEVEL_SHIFT_EN is defined.
module raster_to_block
  import r2b_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [BW_W-1:0] cfg_bw,
  input  logic            in_valid,
  input  row_t            in_data,
  input  logic            in_sof,
  input  logic            in_eof,
  output logic            out_valid,
  output row_t            out_data,
  output logic            out_sob,
  output logic            out_eob,
  output logic            out_sof,
  output logic            err
);

  logic [COL_W-1:0] col;
  logic [2:0]       line;
  logic             sel_i;
  logic [BW_W-1:0]  bw;
  logic             cur_sof;
  logic [1:0]       full;
  logic [1:0]       strip_sof;
  logic [BW_W-1:0]  strip_bw [2];

  r2b_state_t       state;
  logic             sel_o;
  logic [COL_W-1:0] blk;
  logic [2:0]       row;

  logic             accept;
  logic             wr_en;
  logic [BW_W-1:0]  bw_eff;
  logic [2:0]       wr_line;
  logic [COL_W-1:0] wr_col;
  logic             at_last_col;
  logic             bad_eof;
  logic [BW_W-1:0]  bw_o;
  logic             last_blk;
  logic             drain_done;
  row_t             rd_data;

  // An sof beat always lands at the start of the strip, restarting it if needed.
  always_comb begin
    accept      = in_valid & en;
    wr_en       = accept & ~full[sel_i];
    bw_eff      = in_sof ? sat_bw(cfg_bw) : bw;
    wr_line     = in_sof ? 3'd0 : line;
    wr_col      = in_sof ? '0 : col;
    at_last_col = (BW_W'(wr_col) == bw_eff - BW_W'(1));
    bad_eof     = in_eof & ~((wr_line == 3'd7) & at_last_col);
    bw_o        = strip_bw[sel_o];
    last_blk    = (BW_W'(blk) == bw_o - BW_W'(1));
    drain_done  = en & (state == RUN) & (row == 3'd7) & last_blk;
  end

  // Fill side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col         <= '0;
      line        <= '0;
      sel_i       <= 1'b0;
      bw          <= BW_W'(1);
      cur_sof     <= 1'b0;
      full        <= '0;
      strip_sof   <= '0;
      strip_bw[0] <= BW_W'(1);
      strip_bw[1] <= BW_W'(1);
      err         <= 1'b0;
    end else if (en) begin
      if (drain_done)
        full[sel_o] <= 1'b0;
      if (accept) begin
        if (in_sof)
          bw <= sat_bw(cfg_bw);
        if (full[sel_i]) begin
          err <= 1'b1;
        end else begin
          if (in_sof && (line != 3'd0 || col != '0))
            err <= 1'b1;
          if (wr_line == 3'd0 && wr_col == '0)
            cur_sof <= in_sof;
          if (bad_eof) begin
            err  <= 1'b1;
            line <= '0;
            col  <= '0;
          end else if (at_last_col) begin
            col <= '0;
            if (wr_line == 3'd7) begin
              full[sel_i]      <= 1'b1;
              strip_sof[sel_i] <= cur_sof;
              strip_bw[sel_i]  <= bw_eff;
              sel_i            <= ~sel_i;
              line             <= '0;
            end else begin
              line <= wr_line + 3'd1;
            end
          end else begin
            line <= wr_line;
            col  <= wr_col + COL_W'(1);
          end
        end
      end
    end
  end

  // Drain side: framing registers line up with the RAM read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_o     <= 1'b0;
      blk       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_sof   <= 1'b0;
    end else if (en) begin
      out_valid <= (state == RUN);
      out_sob   <= (state == RUN) && (row == 3'd0);
      out_eob   <= (state == RUN) && (row == 3'd7);
      out_sof   <= (state == RUN) && (row == 3'd0) && (blk == '0) && strip_sof[sel_o];
      case (state)
        IDLE: begin
          if (full[sel_o]) begin
            state <= RUN;
            blk   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (row == 3'd7) begin
            row <= '0;
            if (last_blk) begin
              blk   <= '0;
              sel_o <= ~sel_o;
              state <= full[~sel_o] ? RUN : IDLE;
            end else begin
              blk <= blk + COL_W'(1);
            end
          end else begin
            row <= row + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  r2b_strip_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_sel  (sel_i),
    .wr_line (wr_line),
    .wr_col  (wr_col),
    .wr_data (in_data),
    .rd_en   (state == RUN),
    .rd_sel  (sel_o),
    .rd_line (row),
    .rd_col  (blk),
    .rd_data (rd_data)
  );

`ifdef R2B_LEVEL_SHIFT_EN
  function automatic logic [W_IO-1:0] level_shift(input logic [7:0] px);
    logic signed [W_IO-1:0] s;
    s = $signed({{(W_IO-8){1'b0}}, px}) - $signed(W_IO'(128));
    return s;
  endfunction
`endif

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int i = 0; i < 8; i++) begin
`ifdef R2B_LEVEL_SHIFT_EN
        out_data[i] = level_shift(rd_data[i][7:0]);
`else
        out_data[i] = rd_data[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_raster_to_block.sv
// Scoreboard bench for raster_to_block: a queue-based strip model predicts every output row.
module tb_raster_to_block;
  import r2b_pkg::*;

  typedef struct packed {
    row_t d;
    logic sob;
    logic eob;
    logic sof;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [BW_W-1:0] cfg_bw = '0;
  logic            in_valid = 1'b0;
  row_t            in_data = '0;
  logic            in_sof = 1'b0;
  logic            in_eof = 1'b0;
  logic            out_valid;
  row_t            out_data;
  logic            out_sob, out_eob, out_sof, err;

  raster_to_block dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_bw(cfg_bw),
    .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob), .out_eob(out_eob),
    .out_sof(out_sof), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t e;
  int   out_cnt = 0;
  int   first_cyc = 0, last_cyc = 0, lat_cyc = -100, last_acc = 0;
  bit   lat_arm = 0;
  bit   rand_en = 0;

  // Reference model state: beats of the strip being collected
  row_t mq[$];
  int   mbw = 1;
  bit   mtag = 0;
  bit   exp_err = 0;

  function automatic row_t xform(input row_t d);
    row_t r;
    for (int i = 0; i < 8; i++) begin
`ifdef R2B_LEVEL_SHIFT_EN
      r[i] = W_IO'(d[i][7:0]) - W_IO'(128);
`else
      r[i] = d[i];
`endif
    end
    return r;
  endfunction

  task automatic model_beat(input row_t d, input bit sof, input bit eof, input int cfg);
    exp_t x;
    if (sof) begin
      if (mq.size() != 0) exp_err = 1;
      mq.delete();
      mbw = (cfg == 0) ? 1 : (cfg > MAX_BW) ? MAX_BW : cfg;
    end
    if (mq.size() == 0) mtag = sof;
    mq.push_back(d);
    if (mq.size() == 8 * mbw) begin
      for (int b = 0; b < mbw; b++)
        for (int r = 0; r < 8; r++) begin
          x.d   = xform(mq[r * mbw + b]);
          x.sob = (r == 0);
          x.eob = (r == 7);
          x.sof = (r == 0) && (b == 0) && mtag;
          exp_q.push_back(x);
        end
      mq.delete();
    end else if (eof) begin
      exp_err = 1;
      mq.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && en && out_valid) begin
      out_cnt++;
      if (out_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (lat_arm) begin
        lat_cyc = cyc;
        lat_arm = 0;
      end
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_row: got %h sob=%b eob=%b sof=%b, required no output",
                 out_data, out_sob, out_eob, out_sof);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_sob, out_eob, out_sof} !== e) begin
          fails++;
          $display("FAIL row: got %h sob=%b eob=%b sof=%b, required %h sob=%b eob=%b sof=%b",
                   out_data, out_sob, out_eob, out_sof, e.d, e.sob, e.eob, e.sof);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic send(input row_t d, input bit sof, input bit eof);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_eof   = eof;
    for (int k = 0; k < 64 && !acc; k++) begin
      en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      acc = en;
      #1;
    end
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no accepted beat, required acceptance");
    end else begin
      last_acc = cyc;
      model_beat(d, sof, eof, int'(cfg_bw));
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  function automatic row_t make_row(input int mode, input int k);
    row_t d;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       d[i] = W_IO'(8 * k + i);
        1:       d[i] = W_IO'($urandom_range(0, 255));
        default: d[i] = (i % 3 == 0) ? W_IO'(0) : (i % 3 == 1) ? W_IO'(128) : W_IO'(255);
      endcase
    end
    return d;
  endfunction

  task automatic frame(input int bw_cfg, input int nbeats, input int mode);
    cfg_bw = BW_W'(bw_cfg);
    for (int k = 0; k < nbeats; k++)
      send(make_row(mode, k), k == 0, k == nbeats - 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d rows outstanding, required 0", exp_q.size());
    end
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_framing", {29'd0, out_sob, out_eob, out_sof}, 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_data", 32'(out_data != '0), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    #1;

    // bw=2 single strip, counting beats, latency measured
    out_cnt = 0;
    lat_arm = 1;
    frame(2, 16, 0);
    drain(200);
    check("t1_count", 32'(out_cnt), 16);
    check("t1_latency", 32'(lat_cyc - last_acc), 2);
    check("t1_err", 32'(err), 0);

    // bw=4 two strips back-to-back, must drain without bubbles
    out_cnt = 0;
    frame(4, 64, 0);
    drain(300);
    check("t2_count", 32'(out_cnt), 64);
    check("t2_contiguous", 32'(last_cyc - first_cyc), 63);
    check("t2_err", 32'(err), 0);

    // bw=2 with random clock enable
    rand_en = 1;
    out_cnt = 0;
    frame(2, 16, 0);
    drain(3000);
    rand_en = 0;
    check("t3_count", 32'(out_cnt), 16);

    // width 0 behaves as one block
    out_cnt = 0;
    frame(0, 8, 1);
    drain(200);
    check("t4_count_bw0", 32'(out_cnt), 8);

    // oversize width saturates to MAX_BW
    out_cnt = 0;
    frame(MAX_BW + 5, 8 * MAX_BW, 1);
    drain(3000);
    check("t5_count_bwmax", 32'(out_cnt), 8 * MAX_BW);

    // extreme pixel values through the optional level shift
    out_cnt = 0;
    frame(1, 8, 2);
    drain(200);
    check("t6_count", 32'(out_cnt), 8);
    check("t6_err", 32'(err), 0);

    // sof injected at line 3 col 1 restarts the strip and flags an error
    out_cnt = 0;
    cfg_bw  = BW_W'(2);
    for (int k = 0; k < 7; k++) send(make_row(0, k), k == 0, 1'b0);
    send(make_row(0, 100), 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) send(make_row(0, 100 + k), 1'b0, k == 15);
    drain(300);
    check("t7_err", 32'(err), 32'(exp_err));
    check("t7_err_set", 32'(err), 1);
    check("t7_count", 32'(out_cnt), 16);

    // reset with a completed strip pending discards it
    out_cnt = 0;
    frame(1, 8, 1);
    rst_n = 1'b0;
    exp_q.delete();
    mq.delete();
    #20;
    check("t8_rst_err", 32'(err), 0);
    check("t8_rst_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t8_no_output", 32'(out_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
